// File: rtl/clock_pkg.sv
// Shared definitions for the clock set-stage controllers (seconds, minutes, hours).
//
// Contents:
//   state_t      - controller state encoding (ST_RUN=0, ST_EDIT=1, ST_COMMIT=2)
//   SEC_MAX      - highest seconds value; edit arithmetic wraps here
//   cnt_width()  - width needed for a counter that runs 0..n-1 (never less than 1)
package clock_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_EDIT   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   localparam logic [5:0] SEC_MAX = 6'd59;

   function automatic int cnt_width(input int n);
      if (n <= 2) begin
         return 1;
      end
      return $clog2(n);
   endfunction

endpackage

// File: rtl/sec_set_ctrl_if.sv
// Signal bundle between the seconds set-stage controller, the user panel and counter_sec.
//
// Signals:
//   btn_mode, btn_inc, btn_dec - raw asynchronous active-high buttons
//   count_sec[5:0]             - current counter_sec value, sampled on entry to EDIT
//   enable_sec                 - one-cycle count-enable tick to counter_sec
//   load_sec                   - one-cycle load strobe to counter_sec
//   data_sec[5:0]              - load value / live edit value
//   set_active                 - high while the user is editing
//
// Modports:
//   master - the controller (drives enable/load/data/set_active)
//   slave  - the panel + counter side (drives buttons and count_sec)
interface sec_set_ctrl_if;

   logic       btn_mode;
   logic       btn_inc;
   logic       btn_dec;
   logic [5:0] count_sec;
   logic       enable_sec;
   logic       load_sec;
   logic [5:0] data_sec;
   logic       set_active;

   modport master (
      input  btn_mode, btn_inc, btn_dec, count_sec,
      output enable_sec, load_sec, data_sec, set_active
   );

   modport slave (
      output btn_mode, btn_inc, btn_dec, count_sec,
      input  enable_sec, load_sec, data_sec, set_active
   );

endinterface

// File: rtl/btn_cond.sv
// Button conditioner: 2-flop synchronizer, optional level filter, rising-edge detect.
// Produces a one-cycle press pulse per accepted rising level; a held button gives
// exactly one pulse (no auto-repeat).
//
// Optional feature macro: SEC_SET_DEBOUNCE_EN
//   defined   - synced level accepted only after DB_CYCLES consecutive equal samples;
//               press latency DB_CYCLES+3 cycles from the raw rising edge
//   undefined - no filter; press latency 3 cycles; DB_CYCLES parameter not present
//
// Ports:
//   clock - system clock, rising edge
//   reset - synchronous active-high reset
//   raw   - raw asynchronous button level
//   press - one-cycle press pulse (registered)
module btn_cond
`ifdef SEC_SET_DEBOUNCE_EN
#(
   parameter int DB_CYCLES = 1000000
)
`endif
(
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic press
);

   logic sync1_reg;
   logic sync2_reg;
   logic level;
   logic level_prev_reg;
   logic press_reg;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
      end else begin
         sync1_reg <= raw;
         sync2_reg <= sync1_reg;
      end
   end

`ifdef SEC_SET_DEBOUNCE_EN
   localparam int DBW = clock_pkg::cnt_width(DB_CYCLES);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

   logic           stable_reg;
   logic [DBW-1:0] db_cnt_reg;

   // The counter measures how long the synced level has differed from the
   // accepted level; any sample agreeing with the accepted level restarts it.
   always_ff @(posedge clock) begin
      if (reset) begin
         stable_reg <= 1'b0;
         db_cnt_reg <= '0;
      end else if (sync2_reg == stable_reg) begin
         db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_LAST) begin
         stable_reg <= sync2_reg;
         db_cnt_reg <= '0;
      end else begin
         db_cnt_reg <= db_cnt_reg + 1'b1;
      end
   end

   assign level = stable_reg;
`else
   assign level = sync2_reg;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         level_prev_reg <= 1'b0;
         press_reg      <= 1'b0;
      end else begin
         level_prev_reg <= level;
         press_reg      <= level & ~level_prev_reg;
      end
   end

   assign press = press_reg;

endmodule

// File: rtl/sec_set_ctrl.sv
// Seconds set-stage controller: upstream of counter_sec.
//   RUN    - prescaler divides the clock into a one-cycle enable_sec tick every DIV cycles
//   EDIT   - counting frozen; inc/dec adjust the edit value (wrapping at 0 / SEC_MAX)
//   COMMIT - one-cycle load_sec with the edited value, then back to RUN
// EDIT aborts to RUN without a load after EDIT_TIMEOUT cycles without any press.
//
// Optional feature macro: SEC_SET_DEBOUNCE_EN (button debounce, adds DB_CYCLES parameter).
//
// Ports:
//   clock - system clock, rising edge
//   reset - synchronous active-high reset
//   bus   - sec_set_ctrl_if.master: buttons/count_sec in, enable/load/data/set_active out
module sec_set_ctrl
   import clock_pkg::*;
#(
   parameter int DIV          = 100000000,
   parameter int EDIT_TIMEOUT = 1000000000
`ifdef SEC_SET_DEBOUNCE_EN
   ,
   parameter int DB_CYCLES    = 1000000
`endif
)
(
   input  logic            clock,
   input  logic            reset,
   sec_set_ctrl_if.master  bus
);

   localparam int PW = cnt_width(DIV);
   localparam int TW = cnt_width(EDIT_TIMEOUT);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(EDIT_TIMEOUT - 1);

   // ---------------------------------------------------------------
   // Button conditioning: bit 0 = mode, bit 1 = inc, bit 2 = dec
   // ---------------------------------------------------------------
   logic [2:0] raw_btn;
   logic [2:0] press;
   logic       p_mode;
   logic       p_inc;
   logic       p_dec;

   assign raw_btn = {bus.btn_dec, bus.btn_inc, bus.btn_mode};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_btn
         btn_cond
`ifdef SEC_SET_DEBOUNCE_EN
            #(.DB_CYCLES(DB_CYCLES))
`endif
            u_cond (
               .clock (clock),
               .reset (reset),
               .raw   (raw_btn[gi]),
               .press (press[gi])
            );
      end
   endgenerate

   assign p_mode = press[0];
   assign p_inc  = press[1];
   assign p_dec  = press[2];

   // ---------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------
   state_t        state_reg,      state_next;
   logic [5:0]    edit_reg,       edit_next;
   logic [PW-1:0] presc_reg,      presc_next;
   logic [TW-1:0] tmo_reg,        tmo_next;
   logic          enable_reg,     enable_next;
   logic          load_reg,       load_next;
   logic          set_active_reg, set_active_next;

   logic [5:0] edit_inc;
   logic [5:0] edit_dec;

   assign edit_inc = (edit_reg == SEC_MAX) ? 6'd0 : edit_reg + 6'd1;
   assign edit_dec = (edit_reg == 6'd0) ? SEC_MAX : edit_reg - 6'd1;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg      <= ST_RUN;
         edit_reg       <= 6'd0;
         presc_reg      <= '0;
         tmo_reg        <= '0;
         enable_reg     <= 1'b0;
         load_reg       <= 1'b0;
         set_active_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         edit_reg       <= edit_next;
         presc_reg      <= presc_next;
         tmo_reg        <= tmo_next;
         enable_reg     <= enable_next;
         load_reg       <= load_next;
         set_active_reg <= set_active_next;
      end
   end

   // Outputs are computed for the state being entered, so every output is a
   // plain register and load_sec coincides exactly with the COMMIT cycle.
   always_comb begin
      state_next      = state_reg;
      edit_next       = edit_reg;
      presc_next      = presc_reg;
      tmo_next        = tmo_reg;
      enable_next     = 1'b0;
      load_next       = 1'b0;
      set_active_next = 1'b0;

      case (state_reg)
         ST_RUN: begin
            if (p_mode) begin
               state_next      = ST_EDIT;
               edit_next       = (bus.count_sec > SEC_MAX) ? 6'd0 : bus.count_sec;
               presc_next      = '0;
               tmo_next        = '0;
               set_active_next = 1'b1;
            end else if (presc_reg == PRESC_LAST) begin
               presc_next  = '0;
               enable_next = 1'b1;
            end else begin
               presc_next = presc_reg + 1'b1;
            end
         end

         ST_EDIT: begin
            set_active_next = 1'b1;
            presc_next      = '0;
            if (p_mode) begin
               // inc/dec arriving together with mode are deliberately dropped
               state_next      = ST_COMMIT;
               load_next       = 1'b1;
               set_active_next = 1'b0;
               tmo_next        = '0;
            end else if (p_inc || p_dec) begin
               tmo_next = '0;
               if (p_inc && !p_dec) begin
                  edit_next = edit_inc;
               end else if (p_dec && !p_inc) begin
                  edit_next = edit_dec;
               end
            end else if (tmo_reg == TMO_LAST) begin
               state_next      = ST_RUN;
               set_active_next = 1'b0;
               tmo_next        = '0;
            end else begin
               tmo_next = tmo_reg + 1'b1;
            end
         end

         ST_COMMIT: begin
            // Prescaler sat at 0 during the load cycle; counting on from here
            // puts the first tick exactly DIV cycles after load_sec.
            state_next = ST_RUN;
            presc_next = presc_reg + 1'b1;
         end

         default: begin
            state_next = ST_RUN;
            presc_next = '0;
            tmo_next   = '0;
         end
      endcase
   end

   assign bus.enable_sec = enable_reg;
   assign bus.load_sec   = load_reg;
   assign bus.data_sec   = edit_reg;
   assign bus.set_active = set_active_reg;

endmodule

// File: tb/tb_sec_set_ctrl.sv
// Directed self-checking bench for sec_set_ctrl (DIV=4).
module tb_sec_set_ctrl;

`ifdef SEC_SET_DEBOUNCE_EN
   localparam int DB   = 5;
   localparam int HOLD = 6;
   localparam int PLAT = DB + 3;
   localparam int GAP  = 8;
   localparam int TMO  = 32;
`else
   localparam int HOLD = 2;
   localparam int PLAT = 3;
   localparam int GAP  = 1;
   localparam int TMO  = 16;
`endif
   localparam int DIV = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   sec_set_ctrl_if bus();

   sec_set_ctrl #(
      .DIV          (DIV),
      .EDIT_TIMEOUT (TMO)
`ifdef SEC_SET_DEBOUNCE_EN
      ,
      .DB_CYCLES    (DB)
`endif
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // load_sec and enable_sec must never coincide
   always @(negedge clock) begin
      if (!reset) begin
         check("load_enable_excl", int'(bus.load_sec & bus.enable_sec), 0);
      end
   end

   // m = {dec, inc, mode}; returns on the negedge where the FSM reaction is visible
   task automatic press_btn(input string name, input logic [2:0] m);
      repeat (GAP) @(negedge clock);
      {bus.btn_dec, bus.btn_inc, bus.btn_mode} = m;
      repeat (HOLD) @(negedge clock);
      {bus.btn_dec, bus.btn_inc, bus.btn_mode} = 3'b000;
      repeat (PLAT + 1 - HOLD) @(negedge clock);
      $display("press %s: set_active=%0d data_sec=%0d load_sec=%0d enable_sec=%0d",
               name, bus.set_active, bus.data_sec, bus.load_sec, bus.enable_sec);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.btn_mode  = 1'b0;
      bus.btn_inc   = 1'b0;
      bus.btn_dec   = 1'b0;
      bus.count_sec = 6'd0;

      // ---------------- reset values and run ticks ----------------
      repeat (3) @(negedge clock);
      check("rst_enable", int'(bus.enable_sec), 0);
      check("rst_load",   int'(bus.load_sec),   0);
      check("rst_data",   int'(bus.data_sec),   0);
      check("rst_active", int'(bus.set_active), 0);
      reset = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clock);
         check("run_tick", int'(bus.enable_sec), int'(c % DIV == 0));
         check("run_noload", int'(bus.load_sec), 0);
      end
      $display("run ticks: 12 cycles observed");

      // ---------------- entry and increment wrap ----------------
      bus.count_sec = 6'd58;
      press_btn("mode", 3'b001);
      check("entry_active", int'(bus.set_active), 1);
      check("entry_data",   int'(bus.data_sec),   58);
      check("entry_enable", int'(bus.enable_sec), 0);
      press_btn("inc", 3'b010);
      check("inc_59", int'(bus.data_sec), 59);
      press_btn("inc", 3'b010);
      check("inc_wrap", int'(bus.data_sec), 0);
      press_btn("mode", 3'b001);
      check("commit_load",   int'(bus.load_sec),   1);
      check("commit_data",   int'(bus.data_sec),   0);
      check("commit_active", int'(bus.set_active), 0);
      for (int k = 1; k <= DIV; k++) begin
         @(negedge clock);
         check("post_commit_load", int'(bus.load_sec), 0);
         check("post_commit_tick", int'(bus.enable_sec), int'(k == DIV));
      end

      // ---------------- decrement wrap and simultaneous inc+dec ----------------
      bus.count_sec = 6'd0;
      press_btn("mode", 3'b001);
      check("entry0_data", int'(bus.data_sec), 0);
      press_btn("dec", 3'b100);
      check("dec_wrap", int'(bus.data_sec), 59);
      press_btn("inc+dec", 3'b110);
      check("incdec_data",   int'(bus.data_sec),   59);
      check("incdec_active", int'(bus.set_active), 1);
      press_btn("mode", 3'b001);
      check("commit2_load", int'(bus.load_sec), 1);
      check("commit2_data", int'(bus.data_sec), 59);

      // ---------------- out-of-range capture, then timeout abort ----------------
      bus.count_sec = 6'd62;
      press_btn("mode", 3'b001);
      check("entry_clamp", int'(bus.data_sec), 0);
      press_btn("mode", 3'b001);
      check("commit3_load", int'(bus.load_sec), 1);
      bus.count_sec = 6'd10;
      press_btn("mode", 3'b001);
      check("entry10_data", int'(bus.data_sec), 10);
      press_btn("inc", 3'b010);
      check("inc_11", int'(bus.data_sec), 11);
      for (int k = 1; k <= TMO; k++) begin
         @(negedge clock);
         check("timeout_active", int'(bus.set_active), int'(k < TMO));
         check("timeout_noload", int'(bus.load_sec), 0);
      end
      for (int k = 1; k <= 2 * DIV; k++) begin
         @(negedge clock);
         check("abort_tick", int'(bus.enable_sec), int'(k % DIV == 0));
         check("abort_noload", int'(bus.load_sec), 0);
      end
      $display("timeout abort: %0d idle cycles", TMO);

      // ---------------- reset mid-edit ----------------
      bus.count_sec = 6'd20;
      press_btn("mode", 3'b001);
      check("entry20_active", int'(bus.set_active), 1);
      press_btn("inc", 3'b010);
      check("inc_21", int'(bus.data_sec), 21);
      reset = 1'b1;
      @(negedge clock);
      check("midrst_enable", int'(bus.enable_sec), 0);
      check("midrst_load",   int'(bus.load_sec),   0);
      check("midrst_data",   int'(bus.data_sec),   0);
      check("midrst_active", int'(bus.set_active), 0);
      reset = 1'b0;
      for (int k = 1; k <= 2 * DIV; k++) begin
         @(negedge clock);
         check("postrst_tick",   int'(bus.enable_sec), int'(k % DIV == 0));
         check("postrst_noload", int'(bus.load_sec),   0);
         check("postrst_active", int'(bus.set_active), 0);
      end
      $display("reset mid-edit: 8 cycles observed");

`ifdef SEC_SET_DEBOUNCE_EN
      // ---------------- debounce: short glitch rejected, long pulse accepted ----------------
      bus.btn_mode = 1'b1;
      repeat (3) @(negedge clock);
      bus.btn_mode = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clock);
         check("glitch_active", int'(bus.set_active), 0);
      end
      $display("debounce: 3-cycle glitch on btn_mode");
      bus.btn_mode = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clock);
         // press pulse at DB+3, FSM outputs one cycle later
         check("db_entry_active", int'(bus.set_active), int'(k >= DB + 4));
         if (k == 8) bus.btn_mode = 1'b0;
      end
      $display("debounce: 8-cycle pulse on btn_mode");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
